// File: rtl/bp_me_nonsynth_mem_delay_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_nonsynth_pkg
// Shared constants for the memory-path latency-injection stage:
//   - bp_me_nonsynth_delay_lfsr_taps_gp : Galois tap mask for
//     x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
//   - bp_me_nonsynth_delay_seed_gp      : default LFSR reset value
//   - bp_me_nonsynth_delay_lfsr_step()  : one LFSR advance
// -----------------------------------------------------------------------------
package bp_me_nonsynth_pkg;

    localparam logic [15:0] bp_me_nonsynth_delay_lfsr_taps_gp = 16'hB400;
    localparam logic [15:0] bp_me_nonsynth_delay_seed_gp      = 16'hACE1;

    // Right-shifting Galois step: when the bit shifted out is 1, the tap
    // mask is folded back into the register.
    function automatic logic [15:0] bp_me_nonsynth_delay_lfsr_step(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = state >> 1;
        return state[0] ? (shifted ^ bp_me_nonsynth_delay_lfsr_taps_gp) : shifted;
    endfunction

endpackage

// File: rtl/bp_me_nonsynth_mem_delay_if.sv
// -----------------------------------------------------------------------------
// bp_me_nonsynth_mem_delay_if
// Handshake bundle around the delay stage.
//   v_i / data_i / ready_o : upstream valid-ready enqueue side
//   v_o / data_o / yumi_i  : downstream valid-yumi dequeue side
//   count_o                : current occupancy
// Modports:
//   slave  : the delay stage itself
//   master : whoever drives messages in and consumes them (bench, CCE side)
// -----------------------------------------------------------------------------
interface bp_me_nonsynth_mem_delay_if #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) ();

    localparam int count_width_lp = $clog2(els_p + 1);

    logic                      v_i;
    logic [width_p-1:0]        data_i;
    logic                      ready_o;
    logic                      v_o;
    logic [width_p-1:0]        data_o;
    logic                      yumi_i;
    logic [count_width_lp-1:0] count_o;

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, count_o
    );

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, count_o
    );

endinterface

// File: rtl/bp_me_nonsynth_mem_delay_lfsr.sv
// -----------------------------------------------------------------------------
// bp_me_nonsynth_delay_lfsr
// 16-bit Galois LFSR used as the jitter source of the delay stage.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads seed_p
//   en_i    : advance one step (tied to enqueue by the parent)
//   lfsr_o  : current register value
// -----------------------------------------------------------------------------
module bp_me_nonsynth_delay_lfsr
    import bp_me_nonsynth_pkg::*;
#(
    parameter logic [15:0] seed_p = bp_me_nonsynth_delay_seed_gp
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= seed_p;
        end else if (en_i) begin
            r_lfsr <= bp_me_nonsynth_delay_lfsr_step(r_lfsr);
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/bp_me_nonsynth_mem_delay.sv
// -----------------------------------------------------------------------------
// bp_me_nonsynth_mem_delay
// Latency-injection FIFO for CCE unit-test benches. Each accepted message is
// held for latency_p + jitter cycles (jitter from an LFSR) before it is
// offered downstream; strict FIFO order is kept, so a young message whose
// delay has expired still waits behind the head.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, drops every held message
//   io      : slave side of bp_me_nonsynth_mem_delay_if
//             (v_i/data_i/ready_o in, v_o/data_o/yumi_i out, count_o)
// Parameters: width_p (message bits, set by every instantiation), els_p
// (depth, >= 2), latency_p (>= 1), jitter_width_p (0..8), seed_p (!= 0).
// -----------------------------------------------------------------------------
module bp_me_nonsynth_mem_delay
    import bp_me_nonsynth_pkg::*;
#(
    parameter int          width_p        = 8,
    parameter int          els_p          = 4,
    parameter int          latency_p      = 1,
    parameter int          jitter_width_p = 0,
    parameter logic [15:0] seed_p         = bp_me_nonsynth_delay_seed_gp
) (
    input logic                      clk_i,
    input logic                      reset_i,
    bp_me_nonsynth_mem_delay_if.slave io
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int delay_width_lp = $clog2(latency_p + (1 << jitter_width_p));
    localparam int count_width_lp = $clog2(els_p + 1);

    // Elaboration-time parameter checks.
    if (latency_p < 1) begin : g_bad_latency
        $error("bp_me_nonsynth_mem_delay: latency_p must be >= 1");
    end
    if (els_p < 2) begin : g_bad_els
        $error("bp_me_nonsynth_mem_delay: els_p must be >= 2");
    end
    if (jitter_width_p < 0 || jitter_width_p > 8) begin : g_bad_jitter
        $error("bp_me_nonsynth_mem_delay: jitter_width_p must be 0..8");
    end
    if (seed_p == 16'h0000) begin : g_bad_seed
        $error("bp_me_nonsynth_mem_delay: seed_p must be nonzero");
    end

    // Storage and per-entry state
    logic [width_p-1:0]        r_mem        [els_p];
    logic                      r_valid      [els_p];
    logic [delay_width_lp-1:0] r_delay      [els_p];
    logic                      w_valid_next [els_p];
    logic [delay_width_lp-1:0] w_delay_next [els_p];

    logic [ptr_width_lp-1:0]   r_head, r_tail, w_head_next, w_tail_next;
    logic [count_width_lp-1:0] r_count, w_count_next;
    logic                      r_ready;

    logic                      w_enq, w_deq, w_v_o;
    logic [15:0]               w_lfsr;
    logic [delay_width_lp-1:0] w_jitter, w_load_delay;

    // Head is offered only once its own countdown has expired.
    assign w_v_o = r_valid[r_head] && (r_delay[r_head] == '0);
    assign w_enq = io.v_i && r_ready;
    assign w_deq = io.yumi_i && w_v_o;

    bp_me_nonsynth_delay_lfsr #(
        .seed_p (seed_p)
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_enq),
        .lfsr_o  (w_lfsr)
    );

    if (jitter_width_p == 0) begin : g_no_jitter
        logic w_unused_lfsr;
        assign w_jitter      = '0;
        assign w_unused_lfsr = ^w_lfsr;
    end else begin : g_jitter
        logic w_unused_lfsr;
        assign w_jitter      = delay_width_lp'(w_lfsr[jitter_width_p-1:0]);
        assign w_unused_lfsr = ^w_lfsr[15:jitter_width_p];
    end

    // Loaded value is D-1 so that a D=1 message is visible the cycle after
    // it is accepted.
    assign w_load_delay = delay_width_lp'(latency_p - 1) + w_jitter;

    assign w_tail_next = !w_enq ? r_tail :
                         (r_tail == ptr_width_lp'(els_p - 1)) ? '0 :
                         r_tail + ptr_width_lp'(1);
    assign w_head_next = !w_deq ? r_head :
                         (r_head == ptr_width_lp'(els_p - 1)) ? '0 :
                         r_head + ptr_width_lp'(1);

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_deq) begin
            w_count_next = r_count + count_width_lp'(1);
        end else if (!w_enq && w_deq) begin
            w_count_next = r_count - count_width_lp'(1);
        end
    end

    // Per-entry next state. Enqueue and dequeue never hit the same slot in
    // one cycle: that would need the buffer both empty and full.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        logic w_enq_here, w_deq_here;
        assign w_enq_here = w_enq && (r_tail == ptr_width_lp'(gi));
        assign w_deq_here = w_deq && (r_head == ptr_width_lp'(gi));

        assign w_valid_next[gi] = w_enq_here ? 1'b1 :
                                  w_deq_here ? 1'b0 : r_valid[gi];

        // Countdown saturates at zero while the entry waits for the head.
        assign w_delay_next[gi] = w_enq_here ? w_load_delay :
                                  (r_valid[gi] && r_delay[gi] != '0) ?
                                      r_delay[gi] - delay_width_lp'(1) :
                                      r_delay[gi];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_valid[i] <= 1'b0;
                r_delay[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            for (int i = 0; i < els_p; i++) begin
                r_valid[i] <= w_valid_next[i];
                r_delay[i] <= w_delay_next[i];
            end
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            // Registered space flag: a slot freed while full shows up next cycle.
            r_ready <= (w_count_next != count_width_lp'(els_p));
        end
    end

    // Message payload: plain RAM, no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_tail] <= io.data_i;
        end
    end

    assign io.ready_o = r_ready;
    assign io.v_o     = w_v_o;
    assign io.data_o  = r_mem[r_head];
    assign io.count_o = r_count;

    // Protocol checks on the neighbours of this stage.
    a_yumi_needs_valid : assert property (
        @(posedge clk_i) disable iff (reset_i) io.yumi_i |-> w_v_o);

    a_data_stable_when_stalled : assert property (
        @(posedge clk_i) disable iff (reset_i)
        (io.v_i && !r_ready) |=> (!io.v_i || $stable(io.data_i)));

endmodule

// File: tb/tb_bp_me_nonsynth_mem_delay.sv
// -----------------------------------------------------------------------------
// tb_bp_me_nonsynth_mem_delay
// Four stage instances with different parameters:
//   A : latency 3, no jitter            (basic latency)
//   B : latency 2, no jitter, 4 entries (back-to-back, fill/stall, reset)
//   C : latency 1, jitter 3, seed 0x0007 -> first D = 8, second D = 4
//   D : latency 2, jitter 4, default seed (random soak with scoreboard)
// -----------------------------------------------------------------------------
module tb_bp_me_nonsynth_mem_delay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_mid;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecnt = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    bp_me_nonsynth_mem_delay_if #(.width_p(8), .els_p(4)) if_a ();
    bp_me_nonsynth_mem_delay_if #(.width_p(8), .els_p(4)) if_b ();
    bp_me_nonsynth_mem_delay_if #(.width_p(8), .els_p(4)) if_c ();
    bp_me_nonsynth_mem_delay_if #(.width_p(8), .els_p(4)) if_d ();

    bp_me_nonsynth_mem_delay #(.width_p(8), .els_p(4), .latency_p(3), .jitter_width_p(0))
        dut_a (.clk_i(clk), .reset_i(rst), .io(if_a));
    bp_me_nonsynth_mem_delay #(.width_p(8), .els_p(4), .latency_p(2), .jitter_width_p(0))
        dut_b (.clk_i(clk), .reset_i(rst | rst_mid), .io(if_b));
    bp_me_nonsynth_mem_delay #(.width_p(8), .els_p(4), .latency_p(1), .jitter_width_p(3),
                               .seed_p(16'h0007))
        dut_c (.clk_i(clk), .reset_i(rst), .io(if_c));
    bp_me_nonsynth_mem_delay #(.width_p(8), .els_p(4), .latency_p(2), .jitter_width_p(4))
        dut_d (.clk_i(clk), .reset_i(rst), .io(if_d));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Bench-side model of the x^16+x^14+x^13+x^11+1 Galois register.
    function automatic logic [15:0] model_lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] data;
        logic       yumi;
        logic       exp_v;
        logic [7:0] exp_data;
        logic [2:0] exp_count;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[15];

    typedef struct {
        logic [7:0] data;
        int         t_enq;
        int         d;
    } sb_t;

    sb_t sb[$];

    task automatic sb_pop_check();
        sb_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL soak_extra: got data %02h expected no message", if_d.data_o);
            return;
        end
        e = sb.pop_front();
        check("soak_order", {24'h0, if_d.data_o}, {24'h0, e.data});
        // This check counted by the n_checks++ above.
        if (ecnt < e.t_enq + e.d - 1) begin
            n_errors++;
            $display("FAIL soak_delay: got visible after edge %0d expected edge >= %0d",
                     ecnt, e.t_enq + e.d - 1);
        end
    endtask

    initial begin
        logic [15:0] lfsr_m;
        logic        stalled;
        int          n_enq;

        // Stimulus table for instance B (latency 2). Inputs go into the edge
        // that follows each row; expected outputs are those seen just before.
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h01, 3'd2, 1'b1};
        vecs[3]  = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h02, 3'd2, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd2, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1};
        vecs[9]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h10, 3'd2, 1'b1};
        vecs[10] = '{1'b1, 8'h13, 1'b0, 1'b1, 8'h10, 3'd3, 1'b1};
        vecs[11] = '{1'b1, 8'h14, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0};
        vecs[12] = '{1'b1, 8'h14, 1'b1, 1'b1, 8'h10, 3'd4, 1'b0};
        vecs[13] = '{1'b1, 8'h14, 1'b0, 1'b1, 8'h11, 3'd3, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd4, 1'b0};

        rst = 1'b1; rst_mid = 1'b0;
        if_a.v_i = 1'b0; if_a.data_i = '0; if_a.yumi_i = 1'b0;
        if_b.v_i = 1'b0; if_b.data_i = '0; if_b.yumi_i = 1'b0;
        if_c.v_i = 1'b0; if_c.data_i = '0; if_c.yumi_i = 1'b0;
        if_d.v_i = 1'b0; if_d.data_i = '0; if_d.yumi_i = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_b", {31'h0, if_b.ready_o}, 32'h0);
        check("rst_v_b",     {31'h0, if_b.v_o},     32'h0);
        check("rst_count_b", {29'h0, if_b.count_o}, 32'h0);
        check("rst_v_a",     {31'h0, if_a.v_o},     32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ready_b", {31'h0, if_b.ready_o}, 32'h1);
        check("post_rst_ready_d", {31'h0, if_d.ready_o}, 32'h1);
        check("post_rst_count_b", {29'h0, if_b.count_o}, 32'h0);
        $display("reset released: ready_o=%0d count_o=%0d", if_b.ready_o, if_b.count_o);

        // ---- back-to-back and fill/stall on B
        for (int i = 0; i < 15; i++) begin
            $display("vec %0d: v_i=%0d data_i=%02h yumi_i=%0d -> v_o=%0d data_o=%02h count_o=%0d ready_o=%0d",
                     i, vecs[i].v, vecs[i].data, vecs[i].yumi,
                     if_b.v_o, if_b.data_o, if_b.count_o, if_b.ready_o);
            check($sformatf("vec%0d_v", i),     {31'h0, if_b.v_o},     {31'h0, vecs[i].exp_v});
            check($sformatf("vec%0d_count", i), {29'h0, if_b.count_o}, {29'h0, vecs[i].exp_count});
            check($sformatf("vec%0d_ready", i), {31'h0, if_b.ready_o}, {31'h0, vecs[i].exp_ready});
            if (vecs[i].exp_v)
                check($sformatf("vec%0d_data", i), {24'h0, if_b.data_o}, {24'h0, vecs[i].exp_data});
            if_b.v_i    = vecs[i].v;
            if_b.data_i = vecs[i].data;
            if_b.yumi_i = vecs[i].yumi;
            step();
        end
        if_b.v_i = 1'b0; if_b.data_i = '0; if_b.yumi_i = 1'b0;

        // ---- reset mid-flight: B holds 4 messages
        rst_mid = 1'b1;
        step();
        check("midrst_v",     {31'h0, if_b.v_o},     32'h0);
        check("midrst_count", {29'h0, if_b.count_o}, 32'h0);
        check("midrst_ready", {31'h0, if_b.ready_o}, 32'h0);
        rst_mid = 1'b0;
        step();
        check("midrst_after_ready", {31'h0, if_b.ready_o}, 32'h1);
        check("midrst_after_count", {29'h0, if_b.count_o}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("midrst_stale%0d", k), {31'h0, if_b.v_o}, 32'h0);
            step();
        end
        $display("mid-flight reset: count_o=%0d v_o=%0d", if_b.count_o, if_b.v_o);

        // ---- basic latency on A (latency 3)
        if_a.v_i = 1'b1; if_a.data_i = 8'hA5;
        step();
        if_a.v_i = 1'b0; if_a.data_i = '0;
        check("lat_a_t1_v",     {31'h0, if_a.v_o},     32'h0);
        check("lat_a_t1_count", {29'h0, if_a.count_o}, 32'h1);
        step();
        check("lat_a_t2_v", {31'h0, if_a.v_o}, 32'h0);
        step();
        check("lat_a_t3_v",    {31'h0, if_a.v_o},    32'h1);
        check("lat_a_t3_data", {24'h0, if_a.data_o}, 32'hA5);
        if_a.yumi_i = 1'b1;
        step();
        if_a.yumi_i = 1'b0;
        check("lat_a_t4_v",     {31'h0, if_a.v_o},     32'h0);
        check("lat_a_t4_count", {29'h0, if_a.count_o}, 32'h0);
        $display("basic latency: 0xA5 delivered after 3 cycles");

        // ---- head-of-line on C: D1 = 8, D2 = 4
        if_c.v_i = 1'b1; if_c.data_i = 8'h31;
        step();
        if_c.data_i = 8'h32;
        step();
        if_c.v_i = 1'b0; if_c.data_i = '0;
        check("hol_count", {29'h0, if_c.count_o}, 32'h2);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("hol_wait%0d", k), {31'h0, if_c.v_o}, 32'h0);
            step();
        end
        check("hol_first_v",    {31'h0, if_c.v_o},    32'h1);
        check("hol_first_data", {24'h0, if_c.data_o}, 32'h31);
        step();
        check("hol_hold_data", {24'h0, if_c.data_o}, 32'h31);
        if_c.yumi_i = 1'b1;
        step();
        if_c.yumi_i = 1'b0;
        check("hol_second_v",    {31'h0, if_c.v_o},    32'h1);
        check("hol_second_data", {24'h0, if_c.data_o}, 32'h32);
        if_c.yumi_i = 1'b1;
        step();
        if_c.yumi_i = 1'b0;
        check("hol_empty_v", {31'h0, if_c.v_o}, 32'h0);
        $display("head-of-line: 0x31 then 0x32 delivered in order");

        // ---- random soak on D
        lfsr_m  = 16'hACE1;
        stalled = 1'b0;
        n_enq   = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("soak_count", {29'h0, if_d.count_o}, sb.size());
            if (!stalled) begin
                if_d.v_i    = ($urandom_range(0, 1) == 1);
                if_d.data_i = 8'($urandom);
            end
            if_d.yumi_i = if_d.v_o && ($urandom_range(0, 2) != 0);
            if (if_d.yumi_i) sb_pop_check();
            if (if_d.v_i && if_d.ready_o) begin
                sb.push_back('{if_d.data_i, ecnt + 1, 2 + int'(lfsr_m[3:0])});
                lfsr_m = model_lfsr_next(lfsr_m);
                n_enq++;
            end
            stalled = if_d.v_i && !if_d.ready_o;
            step();
        end
        if_d.v_i = 1'b0;
        for (int k = 0; k < 400 && sb.size() > 0; k++) begin
            if_d.yumi_i = if_d.v_o;
            if (if_d.yumi_i) sb_pop_check();
            step();
        end
        if_d.yumi_i = 1'b0;
        check("soak_drain_left",  sb.size(), 32'h0);
        check("soak_drain_count", {29'h0, if_d.count_o}, 32'h0);
        check("soak_drain_v",     {31'h0, if_d.v_o},     32'h0);
        $display("soak: %0d messages enqueued and drained", n_enq);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
